fir_ordonnanceur: RTL and testbench

Controller that sequences one firRAM-style FIR engine (single history buffer, coefficient RAM, one-cycle `nouvel_echantillon` / `traitement_fini` handshake).
- Arbitrates between the real-time sample stream and host coefficient writes, so coefficient RAM is never written while a MAC pass runs.
- Buffers one pending sample and one pending coefficient.
- Detects overrun, bad coefficient addresses and engine timeout.
- Sits between the audio sample source / register bus and the FIR instance.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_tampon_1.sv | 47 ++++
 rtl/fir_ordonnanceur.sv | 167 ++++++++++++++++
 tb/tb_fir_ordonnanceur.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencer: state encoding, address width, timeout default.
package fir_pkg;

  // Coefficient RAM address width seen by the engine.
  localparam int unsigned CoefAddrW = 8;

  // Overrun counter width (saturates at all-ones).
  localparam int unsigned CntOvrW = 8;

  typedef enum logic [2:0] {
    StRepos,
    StLance,
    StCalcul,
    StSortie,
    StCoef
  } etat_e;

  // Engine needs 3 + 2*ordre cycles; leave generous margin before declaring it hung.
  function automatic int unsigned timeout_defaut(input int unsigned ordre);
    return 4 * ordre + 16;
  endfunction

endpackage

// File: rtl/fir_tampon_1.sv
// One-entry holding register with valid flag. A capture into a full entry is dropped
// and flagged; the held entry is kept.
module fir_tampon_1 #(
  parameter int unsigned Width          = 16,
  // When set, an entry being cleared this cycle counts as empty, so a new capture
  // in the same cycle is accepted instead of dropped.
  parameter bit          CaptureOnClear = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             capture_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             drop_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             full;
  logic             accept;

  // Next-state: accept into an empty (or emptying) entry, otherwise drop.
  always_comb begin
    full    = valid_q & ~(CaptureOnClear & clear_i);
    drop_o  = capture_i & full;
    accept  = capture_i & ~full;
    valid_d = accept | (valid_q & ~clear_i);
    data_d  = accept ? data_i : data_q;
  end

  // Entry state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fir_ordonnanceur.sv
// Sequencer for a single FIR engine: holds one sample and one coefficient write,
// launches MAC passes, keeps coefficient writes out of running passes, and flags
// overrun, bad coefficient writes and engine timeout.
module fir_ordonnanceur
  import fir_pkg::*;
#(
  parameter int unsigned ordreFir = 10,
  parameter int unsigned N        = 16,
  parameter int unsigned TIMEOUT  = timeout_defaut(ordreFir)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ech_valide,
  input  logic [N-1:0]         ech_data,
  input  logic                 coef_wr,
  input  logic [CoefAddrW-1:0] coef_addr,
  input  logic [N-1:0]         coef_data,
  output logic                 coef_pret,
  input  logic                 efface_err,
  output logic [N-1:0]         sortie,
  output logic                 sortie_valide,
  output logic                 occupe,
  output logic                 err_overrun,
  output logic                 err_coef,
  output logic                 err_timeout,
  output logic [CntOvrW-1:0]   cnt_overrun,
  output logic [N-1:0]         fir_entree,
  output logic                 fir_nouvel_echantillon,
  input  logic [N-1:0]         fir_sortie,
  input  logic                 fir_fini,
  output logic [N-1:0]         fir_g0,
  output logic [CoefAddrW-1:0] fir_waddr_coef,
  output logic                 fir_ecrit_coef
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  etat_e               etat_q, etat_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [N-1:0]        sortie_q, sortie_d;
  logic                err_overrun_q, err_overrun_d;
  logic                err_coef_q, err_coef_d;
  logic                err_timeout_q, err_timeout_d;
  logic [CntOvrW-1:0]  cnt_overrun_q, cnt_overrun_d;
  logic [CntOvrW-1:0]  cnt_base;

  logic                ech_plein, ech_perdu;
  logic [N-1:0]        ech_tenu;
  logic                coef_plein, coef_refuse;
  logic [CoefAddrW+N-1:0] coef_tenu;
  logic                addr_ok;
  logic                timeout_evt;

  assign addr_ok = (32'(coef_addr) < ordreFir);

  fir_tampon_1 #(
    .Width          (N),
    .CaptureOnClear (1'b1)
  ) u_tampon_ech (
    .clk_i     (clk),
    .rst_ni    (reset),
    .capture_i (ech_valide),
    .clear_i   (etat_q == StLance),
    .data_i    (ech_data),
    .valid_o   (ech_plein),
    .data_o    (ech_tenu),
    .drop_o    (ech_perdu)
  );

  // Coefficient entry must stay locked while it is being written to the engine,
  // so a write during COEF is refused rather than accepted.
  fir_tampon_1 #(
    .Width          (CoefAddrW + N),
    .CaptureOnClear (1'b0)
  ) u_tampon_coef (
    .clk_i     (clk),
    .rst_ni    (reset),
    .capture_i (coef_wr & addr_ok),
    .clear_i   (etat_q == StCoef),
    .data_i    ({coef_addr, coef_data}),
    .valid_o   (coef_plein),
    .data_o    (coef_tenu),
    .drop_o    (coef_refuse)
  );

  // Next-state logic: samples take priority over coefficient writes.
  always_comb begin
    etat_d      = etat_q;
    cnt_d       = cnt_q;
    sortie_d    = sortie_q;
    timeout_evt = 1'b0;
    case (etat_q)
      StRepos: begin
        if (ech_plein) begin
          etat_d = StLance;
        end else if (coef_plein) begin
          etat_d = StCoef;
        end
      end
      StLance: begin
        cnt_d  = '0;
        etat_d = StCalcul;
      end
      StCalcul: begin
        cnt_d = cnt_q + 1'b1;
        if (fir_fini) begin
          sortie_d = fir_sortie;
          etat_d   = StSortie;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          etat_d      = StRepos;
        end
      end
      StSortie: etat_d = StRepos;
      StCoef:   etat_d = StRepos;
      default:  etat_d = StRepos;
    endcase
  end

  // Sticky error flags; a new error in the same cycle as a clear wins.
  always_comb begin
    err_overrun_d = (err_overrun_q & ~efface_err) | ech_perdu;
    err_coef_d    = (err_coef_q & ~efface_err) | (coef_wr & (~addr_ok | coef_refuse));
    err_timeout_d = (err_timeout_q & ~efface_err) | timeout_evt;
    cnt_base      = efface_err ? '0 : cnt_overrun_q;
    cnt_overrun_d = (ech_perdu && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
  end

  // Engine-side and status outputs are decoded from the current state only.
  always_comb begin
    fir_nouvel_echantillon       = (etat_q == StLance);
    fir_entree                   = (etat_q == StLance) ? ech_tenu : '0;
    fir_ecrit_coef               = (etat_q == StCoef);
    {fir_waddr_coef, fir_g0}     = (etat_q == StCoef) ? coef_tenu : '0;
    sortie_valide                = (etat_q == StSortie);
    occupe                       = (etat_q != StRepos);
  end

  // State, result and error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      etat_q        <= StRepos;
      cnt_q         <= '0;
      sortie_q      <= '0;
      err_overrun_q <= 1'b0;
      err_coef_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      cnt_overrun_q <= '0;
    end else begin
      etat_q        <= etat_d;
      cnt_q         <= cnt_d;
      sortie_q      <= sortie_d;
      err_overrun_q <= err_overrun_d;
      err_coef_q    <= err_coef_d;
      err_timeout_q <= err_timeout_d;
      cnt_overrun_q <= cnt_overrun_d;
    end
  end

  assign sortie      = sortie_q;
  assign coef_pret   = ~coef_plein;
  assign err_overrun = err_overrun_q;
  assign err_coef    = err_coef_q;
  assign err_timeout = err_timeout_q;
  assign cnt_overrun = cnt_overrun_q;

endmodule

// File: tb/tb_fir_ordonnanceur.sv
// Directed bench for fir_ordonnanceur with a behavioural FIR engine model.
module tb_fir_ordonnanceur;

  localparam int unsigned OrdreFir = 10;
  localparam int unsigned N        = 16;
  localparam int unsigned EngLat   = 3 + 2 * OrdreFir;   // 23
  localparam logic [N-1:0] EngRes  = 16'h1234;

  logic         clk = 1'b0;
  logic         reset;
  logic         ech_valide = 1'b0;
  logic [N-1:0] ech_data = '0;
  logic         coef_wr = 1'b0;
  logic [7:0]   coef_addr = '0;
  logic [N-1:0] coef_data = '0;
  logic         coef_pret;
  logic         efface_err = 1'b0;
  logic [N-1:0] sortie;
  logic         sortie_valide;
  logic         occupe;
  logic         err_overrun;
  logic         err_coef;
  logic         err_timeout;
  logic [7:0]   cnt_overrun;
  logic [N-1:0] fir_entree;
  logic         fir_nouvel_echantillon;
  logic [N-1:0] fir_sortie;
  logic         fir_fini;
  logic [N-1:0] fir_g0;
  logic [7:0]   fir_waddr_coef;
  logic         fir_ecrit_coef;

  fir_ordonnanceur #(
    .ordreFir (OrdreFir),
    .N        (N)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .ech_valide             (ech_valide),
    .ech_data               (ech_data),
    .coef_wr                (coef_wr),
    .coef_addr              (coef_addr),
    .coef_data              (coef_data),
    .coef_pret              (coef_pret),
    .efface_err             (efface_err),
    .sortie                 (sortie),
    .sortie_valide          (sortie_valide),
    .occupe                 (occupe),
    .err_overrun            (err_overrun),
    .err_coef               (err_coef),
    .err_timeout            (err_timeout),
    .cnt_overrun            (cnt_overrun),
    .fir_entree             (fir_entree),
    .fir_nouvel_echantillon (fir_nouvel_echantillon),
    .fir_sortie             (fir_sortie),
    .fir_fini               (fir_fini),
    .fir_g0                 (fir_g0),
    .fir_waddr_coef         (fir_waddr_coef),
    .fir_ecrit_coef         (fir_ecrit_coef)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: fini pulses EngLat cycles after the launch pulse unless muted.
  bit          eng_muet = 1'b0;
  int unsigned eng_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_cnt    <= 0;
      fir_fini   <= 1'b0;
      fir_sortie <= '0;
    end else begin
      fir_fini <= 1'b0;
      if (fir_nouvel_echantillon) begin
        if (!eng_muet) eng_cnt <= EngLat - 1;
      end else if (eng_cnt != 0) begin
        eng_cnt <= eng_cnt - 1;
        if (eng_cnt == 1) begin
          fir_fini   <= 1'b1;
          fir_sortie <= EngRes;
        end
      end
    end
  end

  // Event logs, sampled on the falling edge.
  logic [N-1:0] lance_log[$];
  int unsigned  lance_cyc[$];
  logic [7:0]   ecrit_addr[$];
  logic [N-1:0] ecrit_data[$];
  int unsigned  ecrit_cyc[$];
  int unsigned  sv_cyc[$];

  always @(negedge clk) begin
    if (fir_nouvel_echantillon) begin
      lance_log.push_back(fir_entree);
      lance_cyc.push_back(cyc);
    end
    if (fir_ecrit_coef) begin
      ecrit_addr.push_back(fir_waddr_coef);
      ecrit_data.push_back(fir_g0);
      ecrit_cyc.push_back(cyc);
    end
    if (sortie_valide) sv_cyc.push_back(cyc);
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic verifier(input string tag, input logic [31:0] obs, input logic [31:0] att);
    n_cmp++;
    if (obs !== att) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, att);
    end
  endtask

  // All stimulus and checks happen 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic vider_logs();
    lance_log.delete();
    lance_cyc.delete();
    ecrit_addr.delete();
    ecrit_data.delete();
    ecrit_cyc.delete();
    sv_cyc.delete();
  endtask

  task automatic envoyer_ech(input logic [N-1:0] d);
    ech_valide = 1'b1;
    ech_data   = d;
    tick();
    ech_valide = 1'b0;
  endtask

  task automatic ecrire_coef(input logic [7:0] a, input logic [N-1:0] d);
    coef_wr   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_wr   = 1'b0;
  endtask

  task automatic attendre_pret();
    int unsigned k = 0;
    while (!coef_pret && k < 20) begin
      tick();
      k++;
    end
    verifier("attente_coef_pret", {31'd0, coef_pret}, 32'd1);
  endtask

  task automatic attendre_sv(input int unsigned n_att, input int unsigned budget);
    int unsigned k = 0;
    while (sv_cyc.size() < n_att && k < budget) begin
      tick();
      k++;
    end
    verifier("attente_sortie_valide", sv_cyc.size(), n_att);
  endtask

  task automatic effacer();
    efface_err = 1'b1;
    tick();
    efface_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    int unsigned k;
    logic [N-1:0] att_d;

    // Reset state.
    reset = 1'b0;
    repeat (3) tick();
    verifier("reset_sortie", {16'd0, sortie}, 32'd0);
    verifier("reset_coef_pret", {31'd0, coef_pret}, 32'd1);
    verifier("reset_drapeaux",
             {27'd0, err_overrun, err_coef, err_timeout, occupe, sortie_valide}, 32'd0);
    verifier("reset_cnt_overrun", {24'd0, cnt_overrun}, 32'd0);
    verifier("reset_fir_entree_g0", {fir_entree, fir_g0}, 32'd0);
    verifier("reset_fir_ctrl",
             {22'd0, fir_waddr_coef, fir_nouvel_echantillon, fir_ecrit_coef}, 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    verifier("repos_occupe", {31'd0, occupe}, 32'd0);

    // Coefficient load: addr 0..9 with 0x0100, 0x0080, then zeros.
    vider_logs();
    for (int i = 0; i < 10; i++) begin
      attendre_pret();
      att_d = (i == 0) ? 16'h0100 : (i == 1) ? 16'h0080 : 16'h0000;
      ecrire_coef(8'(i), att_d);
    end
    repeat (4) tick();
    verifier("coef_nb_ecritures", ecrit_addr.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      att_d = (i == 0) ? 16'h0100 : (i == 1) ? 16'h0080 : 16'h0000;
      if (i < ecrit_addr.size())
        verifier($sformatf("coef_ecrit_%0d", i), {8'd0, ecrit_addr[i], ecrit_data[i]},
                 {8'd0, 8'(i), att_d});
    end
    verifier("coef_err_coef", {31'd0, err_coef}, 32'd0);

    // Bad coefficient address.
    vider_logs();
    ecrire_coef(8'd10, 16'h7777);
    repeat (3) tick();
    verifier("coef_mauvaise_adr_err", {31'd0, err_coef}, 32'd1);
    verifier("coef_mauvaise_adr_ecrit", ecrit_addr.size(), 32'd0);
    verifier("coef_mauvaise_adr_pret", {31'd0, coef_pret}, 32'd1);
    effacer();
    verifier("coef_efface", {31'd0, err_coef}, 32'd0);
    // New error in the same cycle as the clear keeps the flag set.
    efface_err = 1'b1;
    ecrire_coef(8'hFF, 16'h1111);
    efface_err = 1'b0;
    verifier("efface_vs_erreur", {31'd0, err_coef}, 32'd1);
    effacer();
    verifier("efface_apres", {31'd0, err_coef}, 32'd0);

    // Single sample: launch 0x0400, result after 26 cycles.
    vider_logs();
    t0 = cyc;
    envoyer_ech(16'h0400);
    tick();
    verifier("echantillon_occupe", {31'd0, occupe}, 32'd1);
    attendre_sv(1, 60);
    verifier("echantillon_nb_lance", lance_log.size(), 32'd1);
    if (lance_log.size() > 0)
      verifier("echantillon_entree", {16'd0, lance_log[0]}, 32'h0400);
    if (sv_cyc.size() > 0)
      verifier("echantillon_latence", sv_cyc[0] - t0, 32'd26);
    verifier("echantillon_sortie", {16'd0, sortie}, {16'd0, EngRes});
    tick();
    verifier("echantillon_sv_impulsion", {31'd0, sortie_valide}, 32'd0);
    verifier("echantillon_sortie_tenue", {16'd0, sortie}, {16'd0, EngRes});
    verifier("echantillon_repos", {31'd0, occupe}, 32'd0);

    // Overrun: 0x0001, 0x0002, 0x0003 two cycles apart.
    vider_logs();
    envoyer_ech(16'h0001);
    tick();
    envoyer_ech(16'h0002);
    tick();
    envoyer_ech(16'h0003);
    verifier("overrun_cnt", {24'd0, cnt_overrun}, 32'd1);
    verifier("overrun_err", {31'd0, err_overrun}, 32'd1);
    attendre_sv(2, 100);
    repeat (2) tick();
    verifier("overrun_nb_lance", lance_log.size(), 32'd2);
    if (lance_log.size() > 1)
      verifier("overrun_lances", {lance_log[0], lance_log[1]}, 32'h0001_0002);
    verifier("overrun_cnt_stable", {24'd0, cnt_overrun}, 32'd1);
    effacer();
    verifier("overrun_efface", {23'd0, err_overrun, cnt_overrun}, 32'd0);

    // Timeout: muted engine, 56 cycles in CALCUL.
    vider_logs();
    eng_muet = 1'b1;
    t0 = cyc;
    envoyer_ech(16'h0055);
    k = 0;
    while (!err_timeout && k < 100) begin
      tick();
      k++;
    end
    verifier("timeout_err", {31'd0, err_timeout}, 32'd1);
    verifier("timeout_delai", cyc - t0, 32'd59);
    verifier("timeout_repos", {31'd0, occupe}, 32'd0);
    verifier("timeout_sans_sv", sv_cyc.size(), 32'd0);
    verifier("timeout_sortie_tenue", {16'd0, sortie}, {16'd0, EngRes});
    eng_muet = 1'b0;
    effacer();
    verifier("timeout_efface", {31'd0, err_timeout}, 32'd0);

    // Priority: sample and coefficient in the same cycle.
    vider_logs();
    ech_valide = 1'b1;
    ech_data   = 16'h0321;
    coef_wr    = 1'b1;
    coef_addr  = 8'd5;
    coef_data  = 16'h0BEE;
    tick();
    ech_valide = 1'b0;
    coef_wr    = 1'b0;
    attendre_sv(1, 60);
    k = 0;
    while (ecrit_addr.size() == 0 && k < 10) begin
      tick();
      k++;
    end
    verifier("priorite_nb", {ecrit_addr.size(), lance_log.size()} , {32'd1, 32'd1});
    if (ecrit_cyc.size() > 0 && lance_cyc.size() > 0)
      verifier("priorite_ordre", ecrit_cyc[0] - lance_cyc[0], 32'd26);
    if (ecrit_addr.size() > 0)
      verifier("priorite_coef", {8'd0, ecrit_addr[0], ecrit_data[0]}, 32'h0005_0BEE);
    if (lance_log.size() > 0)
      verifier("priorite_entree", {16'd0, lance_log[0]}, 32'h0321);
    verifier("priorite_err_coef", {31'd0, err_coef}, 32'd0);

    // Reset in the middle of CALCUL.
    vider_logs();
    envoyer_ech(16'h0099);
    repeat (4) tick();
    verifier("reset_calcul_occupe", {31'd0, occupe}, 32'd1);
    reset = 1'b0;
    #1;
    verifier("reset_calcul_repos", {15'd0, occupe, sortie}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (30) tick();
    verifier("reset_calcul_abandon", {sv_cyc.size(), lance_log.size()}, {32'd0, 32'd1});
    verifier("reset_calcul_final", {31'd0, occupe}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
